demux14_stream: RTL and testbench
=================================

// Module: demux14_stream
// PURPOSE
//   Registered 1-to-4 stream demultiplexer; the inverse of our 4:1 select-mux benchmark.
//   It accepts one valid/ready input beat tagged with a 2-bit lane select.
//   It steers the beat into one of four per-lane output registers, each with its own
//   valid/ready handshake.
//   It is the fan-out end of the mux/demux pair used in the FCN placement benchmark set.
// PARAMETERS
//   DATA_W  8   width of each data beat
//   CNT_W   8   width of each per-lane saturating beat counter
// PORTS
//   clk        in   1          single clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   in_data    in   DATA_W     input beat
//   in_sel     in   2          target lane (0..3); ignored when DEMUX_RR_EN is defined
//   in_valid   in   1          input beat present
//   in_ready   out  1          input beat accepted this cycle when in_valid & in_ready
//   out_data   out  4*DATA_W   lane k occupies bits [k*DATA_W +: DATA_W]
//   out_valid  out  4          lane k holds a beat
//   out_ready  in   4          lane k consumer accepts
//   lane_cnt   out  4*CNT_W    beats delivered per lane, lane k at [k*CNT_W +: CNT_W]
// BEHAVIOUR
//   - Reset (async, immediate): out_valid=0, out_data=0, lane_cnt=0, RR pointer=0.
//     in_ready is combinational, so it reads 1 during reset.
//   - Target lane t: in_sel when DEMUX_RR_EN is undefined, otherwise the RR pointer.
//   - Lane buffer: one-entry register per lane. States: EMPTY and FULL.
//     EMPTY -> FULL on accept. FULL -> EMPTY on out_ready with no accept.
//     FULL -> FULL on out_ready with a simultaneous accept (pass-through refill).
//   - in_ready = ~out_valid[t] | out_ready[t]. This is combinational from in_sel, the RR
//     pointer and out_ready[t]. There is no combinational path from in_valid.
//   - Latency: a beat accepted in cycle n is visible on out_data/out_valid in cycle n+1.
//     Throughput is 1 beat/cycle per lane while that lane's consumer holds out_ready=1.
//   - Only lane t can load in a given cycle. The other lanes drain independently, in parallel.
//   - out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
//     out_data keeps its last value after the lane drains.
//   - lane_cnt[k] increments by 1 on each out_valid[k] & out_ready[k] handshake.
//     It saturates at 2^CNT_W-1 and never wraps.
//   - in_valid=0 changes no state apart from draining.
//   - in_sel is sampled only on the accept cycle. Changing in_sel while stalled is legal.
//   - Reset mid-transfer: any buffered beats are discarded with no output handshake.
// CONFIGURATION
//   DEMUX_RR_EN defined:
//     - Round-robin steering; in_sel is unused.
//     - A 2-bit RR pointer advances by 1 on each accepted beat and wraps 3 -> 0.
//     - The pointer holds while the current target lane is stalled; lanes are never skipped.
//   DEMUX_RR_EN undefined:
//     - Steering follows in_sel.
//     - The RR pointer is not instantiated.
// STRUCTURE
//   - Package demux_pkg:
//     - NUM_LANES=4 and SEL_W=2.
//     - typedef logic [SEL_W-1:0] lane_sel_t.
//     - typedef enum {LANE_EMPTY, LANE_FULL} lane_state_t.
//   - Sub-module demux_lane_buf, instantiated 4x:
//     - Contains the one-entry register, the valid flag and the saturating counter.
//     - Ports: clk, rst, load, load_data, out_ready, out_data, out_valid, cnt, can_load.
//   - Top level: target decode, in_ready mux, optional RR pointer.
// TESTING
//   1. Reset, then in_sel=2, in_data=8'hA5, one-cycle in_valid, all out_ready=0
//      -> next cycle out_valid=4'b0100, lane 2 data A5, other lanes unchanged.
//   2. Lane 1 full, out_ready[1]=0, in_sel=1, in_valid=1 -> in_ready=0 and data held.
//      Then raise out_ready[1] -> in_ready=1 the same cycle, new beat appears next cycle.
//   3. Lane 0 out_ready=1 and 10 back-to-back beats 0..9 on sel=0
//      -> 10 consecutive output beats 0..9, lane_cnt[0]=10.
//   4. CNT_W=2, push 5 beats through lane 3 -> lane_cnt[3]=3 (saturated, no wrap).
//   5. Lanes 0 and 3 full, assert rst asynchronously mid-cycle
//      -> out_valid=0 and lane_cnt=0 before the next clock edge.
//   6. DEMUX_RR_EN defined, in_sel fixed at 0, beats 11,22,33,44,55, all out_ready=1
//      -> they land on lanes 0,1,2,3,0. Stall lane 1 -> the pointer stays at 1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] lane_sel_t;

    typedef enum logic {LANE_EMPTY, LANE_FULL} lane_state_t;

    // Round-robin successor; the 2-bit width makes 3 -> 0 wrap naturally.
    function automatic lane_sel_t rr_next(input lane_sel_t p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/demux_lane_buf.sv
// One-entry lane buffer: data register, valid flag (EMPTY/FULL state) and a
// saturating count of delivered beats.
module demux_lane_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [CNT_W-1:0]  cnt,
    output logic              can_load
);

    lane_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // A draining lane can accept a refill in the same cycle.
    assign can_load  = (state_q == LANE_EMPTY) | out_ready;
    assign out_valid = (state_q == LANE_FULL);
    assign out_data  = data_q;
    assign cnt       = cnt_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            LANE_EMPTY: begin
                if (load) begin
                    state_d = LANE_FULL;
                    data_d  = load_data;
                end
            end
            LANE_FULL: begin
                if (out_ready) begin
                    cnt_d = sat_inc(cnt_q);
                    if (load) data_d  = load_data;
                    else      state_d = LANE_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LANE_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/demux14_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with per-lane beat counters.
// Define DEMUX_RR_EN for round-robin lane steering instead of in_sel.
module demux14_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic [SEL_W-1:0]              in_sel,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [NUM_LANES*DATA_W-1:0]   out_data,
    output logic [NUM_LANES-1:0]          out_valid,
    input  logic [NUM_LANES-1:0]          out_ready,
    output logic [NUM_LANES*CNT_W-1:0]    lane_cnt
);

    lane_sel_t            tgt;
    logic                 accept;
    logic [NUM_LANES-1:0] can_load;
    logic [NUM_LANES-1:0] load_vec;

`ifdef DEMUX_RR_EN
    lane_sel_t rr_q, rr_d;
    logic      unused_sel;

    assign unused_sel = ^in_sel;
    assign tgt        = rr_q;
    // Pointer only moves on an accepted beat, so a stalled lane is never skipped.
    assign rr_d       = accept ? rr_next(rr_q) : rr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end
`else
    assign tgt = in_sel;
`endif

    assign in_ready = can_load[tgt];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load_vec      = '0;
        load_vec[tgt] = accept;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_lane_buf #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W]),
            .out_valid (out_valid[k]),
            .cnt       (lane_cnt[k*CNT_W +: CNT_W]),
            .can_load  (can_load[k])
        );
    end

endmodule

// File: tb/tb_demux14_stream.sv
// Scoreboard bench for demux14_stream: per-lane expected-beat queues filled on
// accept and drained by a handshake monitor; second instance with CNT_W=2.
module tb_demux14_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] lane_cnt;

    logic [7:0]  s_in_data;
    logic [1:0]  s_in_sel;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_out_data;
    logic [3:0]  s_out_valid;
    logic [3:0]  s_out_ready;
    logic [7:0]  s_lane_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] sbq [4][$];
    int exp_cnt [4];

    always #5 clk = ~clk;

    demux14_stream #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .lane_cnt(lane_cnt)
    );

    demux14_stream #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_sel(s_in_sel),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .lane_cnt(s_lane_cnt)
    );

    // Output handshakes complete at the following rising edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst === 1'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
                    checks++;
                    if (sbq[k].size() == 0) begin
                        errors++;
                        $display("FAIL lane%0d_unexpected_beat got %h expected none", k, out_data[k*8 +: 8]);
                    end else begin
                        e = sbq[k].pop_front();
                        if (out_data[k*8 +: 8] !== e) begin
                            errors++;
                            $display("FAIL lane%0d_data got %h expected %h", k, out_data[k*8 +: 8], e);
                        end
                    end
                    if (exp_cnt[k] < 255) exp_cnt[k]++;
                end
            end
        end
    end

    task automatic send(input logic [1:0] lane, input logic [1:0] sel, input logic [7:0] d);
        int n;
        in_sel   = sel;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout lane %0d in_ready %b expected 1", lane, in_ready);
        end else begin
            sbq[lane].push_back(d);
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            sbq[k].delete();
            exp_cnt[k] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
        s_in_valid = 1'b0; s_in_sel = 2'd0; s_in_data = 8'h00; s_out_ready = 4'h0;
        clear_model();
        #2;
        checks++;
        if (out_valid !== 4'h0 || lane_cnt !== 32'h0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got valid %b cnt %h data %h expected 0 0 0", out_valid, lane_cnt, out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        out_ready = 4'h0;
        send(2'd2, 2'd2, 8'hA5);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b0100) begin
            errors++;
            $display("FAIL single_valid got %b expected 0100", out_valid);
        end
        checks++;
        if (out_data !== 32'h00A5_0000) begin
            errors++;
            $display("FAIL single_data got %h expected 00a50000", out_data);
        end
        out_ready = 4'hF;
        @(posedge clk); #1;
        out_ready = 4'h0;
    endtask

    task automatic test_stall();
        out_ready = 4'h0;
        send(2'd1, 2'd1, 8'h11);
        in_data = 8'h22;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_data[15:8] !== 8'h11) begin
            errors++;
            $display("FAIL stall_block got ready %b data %h expected 0 11", in_ready, out_data[15:8]);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h11) begin
            errors++;
            $display("FAIL stall_hold got ready %b valid %b data %h expected 0 1 11", in_ready, out_valid[1], out_data[15:8]);
        end
        out_ready[1] = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready got %b expected 1", in_ready);
        end
        sbq[1].push_back(8'h22);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h22) begin
            errors++;
            $display("FAIL stall_refill got valid %b data %h expected 1 22", out_valid[1], out_data[15:8]);
        end
        @(posedge clk); #1;
        out_ready = 4'h0;
        #1;
        checks++;
        if (out_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL stall_drained got %b expected 0", out_valid[1]);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 4'b0001;
        for (int i = 0; i < 10; i++) send(2'd0, 2'd0, 8'(i));
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (lane_cnt[7:0] !== 8'd10 || exp_cnt[0] != 10) begin
            errors++;
            $display("FAIL b2b_count got %0d model %0d expected 10", lane_cnt[7:0], exp_cnt[0]);
        end
        checks++;
        if (sbq[0].size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover got %0d beats expected 0", sbq[0].size());
        end
        out_ready = 4'h0;
    endtask

    task automatic test_saturation();
        s_out_ready = 4'b1000;
        s_in_sel    = 2'd3;
        for (int i = 1; i <= 5; i++) begin
            s_in_data  = 8'(i);
            s_in_valid = 1'b1;
            #1;
            checks++;
            if (s_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sat_ready beat %0d got %b expected 1", i, s_in_ready);
            end
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_lane_cnt[7:6] !== 2'd3 || s_lane_cnt[5:0] !== 6'd0) begin
            errors++;
            $display("FAIL sat_count got %b expected 11000000", s_lane_cnt);
        end
        checks++;
        if (s_out_data[31:24] !== 8'd5 || s_out_valid !== 4'h0) begin
            errors++;
            $display("FAIL sat_last got data %h valid %b expected 05 0000", s_out_data[31:24], s_out_valid);
        end
        s_out_ready = 4'h0;
    endtask

    task automatic test_async_reset();
        out_ready = 4'h0;
        send(2'd0, 2'd0, 8'h5A);
        send(2'd3, 2'd3, 8'hC3);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b1001) begin
            errors++;
            $display("FAIL arst_prefill got %b expected 1001", out_valid);
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 4'h0 || lane_cnt !== 32'h0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_clear got valid %b cnt %h data %h ready %b expected 0 0 0 1",
                     out_valid, lane_cnt, out_data, in_ready);
        end
        clear_model();
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(2'd3, 2'd3, 8'h77);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 4'b1000 || out_data[31:24] !== 8'h77) begin
            errors++;
            $display("FAIL arst_recover got valid %b data %h expected 1000 77", out_valid, out_data[31:24]);
        end
        out_ready = 4'hF;
        @(posedge clk); #1;
        out_ready = 4'h0;
    endtask

    task automatic test_round_robin();
        logic [7:0] beats [5];
        beats = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};
        out_ready = 4'hF;
        for (int i = 0; i < 5; i++) send(2'(i % 4), 2'd0, beats[i]);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (lane_cnt !== 32'h01_01_01_02) begin
            errors++;
            $display("FAIL rr_counts got %h expected 01010102", lane_cnt);
        end
        out_ready = 4'b1101;
        send(2'd1, 2'd0, 8'h66);
        send(2'd2, 2'd0, 8'h77);
        send(2'd3, 2'd0, 8'h88);
        send(2'd0, 2'd0, 8'h99);
        in_data = 8'hAA;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_data[15:8] !== 8'h66) begin
            errors++;
            $display("FAIL rr_stall got ready %b data %h expected 0 66", in_ready, out_data[15:8]);
        end
        @(posedge clk); #1;
        in_sel = 2'd2;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rr_hold got ready %b expected 0", in_ready);
        end
        out_ready[1] = 1'b1;
        send(2'd1, 2'd0, 8'hAA);
        send(2'd2, 2'd0, 8'hBB);
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 4'h0;
    endtask

    task automatic test_drain_all();
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sbq[k].size() != 0) begin
                errors++;
                $display("FAIL drain_lane%0d got %0d pending expected 0", k, sbq[k].size());
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef DEMUX_RR_EN
        test_round_robin();
`else
        test_single();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_async_reset();
`endif
        test_drain_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
